// File: rtl/gpu_spi_pkg.sv
// Shared types for the SPI command dispatcher: command word, FSM states and
// the fill pattern returned when a register read never answers.
package gpu_spi_pkg;

    typedef struct packed {
        logic        rw;
        logic [6:0]  addr;
        logic [63:0] data;
    } cmd_t;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ISSUE    = 2'd1,
        ST_WAIT_RSP = 2'd2
    } state_t;

    localparam logic [63:0] TIMEOUT_FILL = 64'hDEAD_BEEF_DEAD_BEEF;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; head entry is visible on dout
// without a pop, and push/pop are ignored when full/empty respectively.
module sync_fifo #(
    parameter int WIDTH = 72,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Fullness is judged on the registered count, so a same-cycle pop never frees a slot.
    assign do_push = push && (count != DEPTH_C);
    assign do_pop  = pop && (count != '0);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/spi_cmd_dispatch.sv
// Queues decoded SPI commands and issues them one at a time to the register
// file, holding off further commands while a read response is outstanding.
module spi_cmd_dispatch
    import gpu_spi_pkg::*;
#(
    parameter int FIFO_DEPTH  = 16,
    parameter int AFULL_LEVEL = 12,
    parameter int RSP_TIMEOUT = 255
) (
    input  logic                          sys_clk,
    input  logic                          sys_rst_n,
    input  logic                          spi_valid,
    input  logic                          spi_rw,
    input  logic [6:0]                    spi_addr,
    input  logic [63:0]                   spi_wdata,
    output logic [63:0]                   spi_rdata,
    output logic                          reg_req_valid,
    input  logic                          reg_req_ready,
    output logic                          reg_req_rw,
    output logic [6:0]                    reg_req_addr,
    output logic [63:0]                   reg_req_wdata,
    input  logic                          reg_rsp_valid,
    input  logic [63:0]                   reg_rsp_rdata,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          fifo_almost_full,
    output logic                          overflow_err,
    output logic                          timeout_err,
    input  logic                          err_clr
);

    localparam int CW  = $clog2(FIFO_DEPTH) + 1;
    localparam int WCW = $clog2(RSP_TIMEOUT + 1);
    localparam logic [CW-1:0]  FULL_C   = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0]  AFULL_C  = CW'(AFULL_LEVEL);
    localparam logic [WCW-1:0] TMO_LAST = WCW'(RSP_TIMEOUT - 1);

    state_t         state;
    state_t         state_d;
    cmd_t           push_cmd;
    cmd_t           head_cmd;
    logic           fifo_full;
    logic           overflow_evt;
    logic           pop;
    logic           accept;
    logic           rsp_take;
    logic           timeout_evt;
    logic [WCW-1:0] wait_cnt;

    assign push_cmd         = '{rw: spi_rw, addr: spi_addr, data: spi_wdata};
    assign fifo_full        = (fifo_count == FULL_C);
    assign overflow_evt     = spi_valid && fifo_full;
    assign fifo_almost_full = (fifo_count >= AFULL_C);

    sync_fifo #(
        .WIDTH ($bits(cmd_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (sys_clk),
        .rst_n (sys_rst_n),
        .push  (spi_valid && !fifo_full),
        .din   (push_cmd),
        .pop   (pop),
        .dout  (head_cmd),
        .count (fifo_count)
    );

    // reg_req handshake: a request transfers on any cycle with reg_req_valid &&
    // reg_req_ready; while valid is high rw/addr/wdata stay stable and valid
    // only drops in the cycle after the transfer.
    always_comb begin
        state_d     = state;
        pop         = 1'b0;
        accept      = 1'b0;
        rsp_take    = 1'b0;
        timeout_evt = 1'b0;
        case (state)
            ST_IDLE: begin
                if (fifo_count != '0) begin
                    pop     = 1'b1;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (reg_req_ready) begin
                    accept  = 1'b1;
                    state_d = reg_req_rw ? ST_WAIT_RSP : ST_IDLE;
                end
            end
            ST_WAIT_RSP: begin
                if (reg_rsp_valid) begin
                    rsp_take = 1'b1;
                    state_d  = ST_IDLE;
                end else if (wait_cnt == TMO_LAST) begin
                    timeout_evt = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) state <= ST_IDLE;
        else            state <= state_d;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            reg_req_valid <= 1'b0;
            reg_req_rw    <= 1'b0;
            reg_req_addr  <= '0;
            reg_req_wdata <= '0;
            spi_rdata     <= '0;
            wait_cnt      <= '0;
            overflow_err  <= 1'b0;
            timeout_err   <= 1'b0;
        end else begin
            if (pop) begin
                reg_req_valid <= 1'b1;
                reg_req_rw    <= head_cmd.rw;
                reg_req_addr  <= head_cmd.addr;
                reg_req_wdata <= head_cmd.data;
            end else if (accept) begin
                reg_req_valid <= 1'b0;
            end

            // Counter runs only while staying in WAIT_RSP, so every entry starts at zero.
            if (state == ST_WAIT_RSP && state_d == ST_WAIT_RSP) wait_cnt <= wait_cnt + WCW'(1);
            else                                                wait_cnt <= '0;

            if (rsp_take)         spi_rdata <= reg_rsp_rdata;
            else if (timeout_evt) spi_rdata <= TIMEOUT_FILL;

            if (overflow_evt) overflow_err <= 1'b1;
            else if (err_clr) overflow_err <= 1'b0;

            if (timeout_evt)  timeout_err <= 1'b1;
            else if (err_clr) timeout_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_spi_cmd_dispatch.sv
// Directed bench for spi_cmd_dispatch: latency, ordering, overflow, timeout,
// sticky-error clearing and mid-operation reset.
module tb_spi_cmd_dispatch;

    logic        sys_clk;
    logic        sys_rst_n;
    logic        spi_valid;
    logic        spi_rw;
    logic [6:0]  spi_addr;
    logic [63:0] spi_wdata;
    logic [63:0] spi_rdata;
    logic        reg_req_valid;
    logic        reg_req_ready;
    logic        reg_req_rw;
    logic [6:0]  reg_req_addr;
    logic [63:0] reg_req_wdata;
    logic        reg_rsp_valid;
    logic [63:0] reg_rsp_rdata;
    logic [4:0]  fifo_count;
    logic        fifo_almost_full;
    logic        overflow_err;
    logic        timeout_err;
    logic        err_clr;

    int n_vec = 0;
    int n_err = 0;
    logic [71:0] exp_q[$];

    spi_cmd_dispatch #(
        .FIFO_DEPTH  (16),
        .AFULL_LEVEL (12),
        .RSP_TIMEOUT (255)
    ) dut (
        .sys_clk          (sys_clk),
        .sys_rst_n        (sys_rst_n),
        .spi_valid        (spi_valid),
        .spi_rw           (spi_rw),
        .spi_addr         (spi_addr),
        .spi_wdata        (spi_wdata),
        .spi_rdata        (spi_rdata),
        .reg_req_valid    (reg_req_valid),
        .reg_req_ready    (reg_req_ready),
        .reg_req_rw       (reg_req_rw),
        .reg_req_addr     (reg_req_addr),
        .reg_req_wdata    (reg_req_wdata),
        .reg_rsp_valid    (reg_rsp_valid),
        .reg_rsp_rdata    (reg_rsp_rdata),
        .fifo_count       (fifo_count),
        .fifo_almost_full (fifo_almost_full),
        .overflow_err     (overflow_err),
        .timeout_err      (timeout_err),
        .err_clr          (err_clr)
    );

    // Clock and reset defaults
    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One-cycle SPI command pulse; returns one cycle later.
    task automatic spi_send(input logic rw, input logic [6:0] addr, input logic [63:0] data);
        spi_valid = 1'b1;
        spi_rw    = rw;
        spi_addr  = addr;
        spi_wdata = data;
        step();
        spi_valid = 1'b0;
    endtask

    task automatic wait_valid(input int budget);
        int k = 0;
        while (reg_req_valid !== 1'b1 && k < budget) begin
            step();
            k++;
        end
        chk("req_valid_wait", {71'd0, reg_req_valid}, 72'd1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_valid"}, {71'd0, reg_req_valid}, 72'd0);
        chk({tag, "_req"}, {reg_req_rw, reg_req_addr, reg_req_wdata}, 72'd0);
        chk({tag, "_rdata"}, {8'd0, spi_rdata}, 72'd0);
        chk({tag, "_count"}, {67'd0, fifo_count}, 72'd0);
        chk({tag, "_flags"}, {69'd0, fifo_almost_full, overflow_err, timeout_err}, 72'd0);
    endtask

    initial begin
        logic never_valid;
        sys_rst_n     = 1'b0;
        spi_valid     = 1'b0;
        spi_rw        = 1'b0;
        spi_addr      = '0;
        spi_wdata     = '0;
        reg_req_ready = 1'b0;
        reg_rsp_valid = 1'b0;
        reg_rsp_rdata = '0;
        err_clr       = 1'b0;
        repeat (3) step();
        chk_reset_outputs("reset");
        sys_rst_n = 1'b1;
        step();

        // Single write: visible two cycles after the pulse for exactly one cycle
        reg_req_ready = 1'b1;
        spi_send(1'b0, 7'h05, 64'h1122334455667788);
        chk("wr_n1_count", {67'd0, fifo_count}, 72'd1);
        chk("wr_n1_valid", {71'd0, reg_req_valid}, 72'd0);
        step();
        chk("wr_n2_valid", {71'd0, reg_req_valid}, 72'd1);
        chk("wr_n2_req", {reg_req_rw, reg_req_addr, reg_req_wdata}, {1'b0, 7'h05, 64'h1122334455667788});
        chk("wr_n2_count", {67'd0, fifo_count}, 72'd0);
        step();
        chk("wr_n3_valid", {71'd0, reg_req_valid}, 72'd0);

        // Back-to-back writes issue every second cycle
        spi_send(1'b0, 7'h11, 64'hAAAA);
        spi_send(1'b0, 7'h12, 64'hBBBB);
        chk("b2b_n2_valid", {71'd0, reg_req_valid}, 72'd1);
        chk("b2b_n2_addr", {65'd0, reg_req_addr}, 72'h11);
        chk("b2b_n2_count", {67'd0, fifo_count}, 72'd1);
        step();
        chk("b2b_n3_valid", {71'd0, reg_req_valid}, 72'd0);
        step();
        chk("b2b_n4_req", {reg_req_valid, reg_req_addr, reg_req_wdata}, {1'b1, 7'h12, 64'hBBBB});
        step();

        // Read followed by a write: write must wait for the response
        spi_send(1'b1, 7'h10, 64'h0);
        spi_send(1'b0, 7'h21, 64'h2121);
        chk("rd_issue", {reg_req_valid, reg_req_rw, reg_req_addr}, {1'b1, 1'b1, 7'h10});
        step();
        for (int i = 0; i < 3; i++) begin
            chk("rd_wait_no_issue", {71'd0, reg_req_valid}, 72'd0);
            step();
        end
        reg_rsp_valid = 1'b1;
        reg_rsp_rdata = 64'h000000000000CAFE;
        step();
        reg_rsp_valid = 1'b0;
        reg_rsp_rdata = '0;
        chk("rd_rdata", {8'd0, spi_rdata}, {8'd0, 64'h000000000000CAFE});
        chk("rd_then_wr_pending", {reg_req_valid, fifo_count}, {1'b0, 5'd1});
        step();
        chk("rd_then_wr_issue", {reg_req_valid, reg_req_addr, reg_req_wdata}, {1'b1, 7'h21, 64'h2121});
        step();

        // Hold the FSM in WAIT_RSP, then overfill the FIFO with 17 writes
        spi_send(1'b1, 7'h30, 64'h0);
        step();
        step();
        reg_req_ready = 1'b0;
        for (int i = 1; i <= 17; i++) begin
            spi_send(1'b0, 7'h40 + 7'(i), 64'hF000 + 64'(i));
            if (i <= 16) exp_q.push_back({1'b0, 7'h40 + 7'(i), 64'hF000 + 64'(i)});
            if (i == 11) chk("afull_at_11", {71'd0, fifo_almost_full}, 72'd0);
            if (i == 12) chk("afull_at_12", {71'd0, fifo_almost_full}, 72'd1);
            if (i == 16) chk("ovf_at_16", {overflow_err, fifo_count}, {1'b0, 5'd16});
        end
        chk("ovf_at_17", {overflow_err, fifo_almost_full, fifo_count}, {1'b1, 1'b1, 5'd16});
        err_clr = 1'b1;
        spi_send(1'b0, 7'h7F, 64'hBAD);
        err_clr = 1'b0;
        chk("ovf_beats_clr", {overflow_err, fifo_count}, {1'b1, 5'd16});
        reg_rsp_valid = 1'b1;
        reg_rsp_rdata = 64'h1234;
        step();
        reg_rsp_valid = 1'b0;
        chk("fill_rsp_rdata", {8'd0, spi_rdata}, {8'd0, 64'h1234});
        reg_req_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            logic [71:0] exp_cmd;
            wait_valid(4);
            exp_cmd = exp_q.pop_front();
            chk("drain_order", {reg_req_rw, reg_req_addr, reg_req_wdata}, exp_cmd);
            step();
        end
        chk("drain_empty", {reg_req_valid, fifo_count}, {1'b0, 5'd0});

        // Read with no response times out after 255 waiting cycles
        spi_send(1'b1, 7'h33, 64'h0);
        step();
        chk("tmo_issue", {reg_req_valid, reg_req_rw, reg_req_addr}, {1'b1, 1'b1, 7'h33});
        step();
        repeat (254) step();
        chk("tmo_before", {7'd0, timeout_err, spi_rdata}, {8'd0, 64'h1234});
        step();
        chk("tmo_after", {timeout_err, overflow_err, 6'd0, spi_rdata}, {1'b1, 1'b1, 6'd0, 64'hDEADBEEFDEADBEEF});
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("err_clr", {70'd0, overflow_err, timeout_err}, 72'd0);

        // A stray response while idle is ignored
        reg_rsp_valid = 1'b1;
        reg_rsp_rdata = 64'h5555;
        step();
        reg_rsp_valid = 1'b0;
        chk("idle_rsp_ignored", {8'd0, spi_rdata}, {8'd0, 64'hDEADBEEFDEADBEEF});

        // Reset in WAIT_RSP with five commands queued
        spi_send(1'b1, 7'h44, 64'h0);
        step();
        step();
        for (int i = 0; i < 5; i++) spi_send(1'b0, 7'h50 + 7'(i), 64'(i));
        chk("pre_rst_count", {67'd0, fifo_count}, 72'd5);
        #2;
        sys_rst_n = 1'b0;
        #1;
        chk_reset_outputs("mid_reset");
        step();
        step();
        #2;
        sys_rst_n = 1'b1;
        never_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (reg_req_valid !== 1'b0 || fifo_count !== 5'd0) never_valid = 1'b0;
        end
        chk("post_rst_quiet", {71'd0, never_valid}, 72'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
